rvh_l1d_ptw_req_sched: RTL and testbench
========================================

# rvh_l1d_ptw_req_sched

Single-outstanding scheduler for page-table-walk (PTW) requests into the L1D load pipe. It shares the L1D PTW request port between new walk requests from the MMU PTW and replay requests from the PTW replay buffer. It drives the replay buffer's allocate strobe and tracks each walk until its response is taken, with a response timeout watchdog. It sits between the MMU PTW, the PTW replay buffer and the L1D load-pipe PTW port.

## Interface
- PTW_ID_WIDTH, 1, walk ID width
- PADDR_WIDTH, 56, physical address width
- TIMEOUT_CYCLES, 1023, WAIT_RESP cycles before timeout; must be < 2^TO_WIDTH
- TO_WIDTH, 10, timeout counter width

Ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ptw_req_vld_i / ptw_req_id_i / ptw_req_paddr_i  in  1/PTW_ID_WIDTH/PADDR_WIDTH  new walk request from MMU PTW
- ptw_req_rdy_o  out  1  scheduler can accept a new walk
- replay_req_vld_i / replay_req_id_i / replay_req_paddr_i  in  1/PTW_ID_WIDTH/PADDR_WIDTH  replay request from replay buffer
- replay_req_rdy_o  out  1  replay accepted
- l1d_req_vld_o / l1d_req_id_o / l1d_req_paddr_o  out  1/PTW_ID_WIDTH/PADDR_WIDTH  request to L1D PTW port
- l1d_req_rdy_i  in  1  L1D port ready
- buf_alloc_vld_o / buf_alloc_id_o / buf_alloc_paddr_o  out  1/PTW_ID_WIDTH/PADDR_WIDTH  replay-buffer allocate strobe
- ptw_walk_resp_vld_i, ptw_walk_resp_rdy_i  in  1 each  response handshake, observed only
- flush_i  in  1  sfence/flush of translation state
- resp_drop_o  out  1  current response belongs to a flushed walk; PTW must discard it
- busy_o  out  1  state != IDLE
- replay_cnt_o  out  4  replays of the current walk, saturating at 15
- timeout_o  out  1  one-cycle pulse on watchdog expiry
- err_id_mismatch_o  out  1  sticky; replay ID differs from the outstanding walk ID

## Operation
- Holding register: walk {id, paddr}, captured on the new-request handshake. Replay register: {id, paddr}, captured on the replay handshake.
- IDLE:
  - ptw_req_rdy_o=1.
  - On ptw_req_vld_i: capture the request, go to ISSUE.
- ISSUE:
  - l1d_req_vld_o=1 with the held walk.
  - On l1d_req_rdy_i: buf_alloc_vld_o=1 in the same cycle with the held id/paddr, go to WAIT_RESP.
  - flush_i without l1d_req_rdy_i: drop the walk, go to IDLE. If flush_i and l1d_req_rdy_i arrive together, the handshake wins and flush_pending is set.
- WAIT_RESP:
  - replay_req_rdy_o=1.
  - On replay_req_vld_i: capture the replay, increment replay_cnt, go to REPLAY.
  - If replay_req_id_i != held id, set err_id_mismatch_o. The replay is still issued.
  - On response handshake (vld&rdy): go to IDLE.
  - Response and replay in the same cycle: response wins, replay_req_rdy_o is forced 0, go to IDLE.
- REPLAY:
  - l1d_req_vld_o=1 with the replay register.
  - buf_alloc_vld_o stays 0.
  - On l1d_req_rdy_i: go to WAIT_RESP.
  - A response handshake in REPLAY drops the replay and goes to IDLE.
- flush_i in WAIT_RESP/REPLAY sets flush_pending. resp_drop_o = flush_pending & response handshake. flush_pending clears on entry to IDLE.
- Watchdog:
  - Counter clears on entry to WAIT_RESP and counts each WAIT_RESP cycle.
  - When the counter reaches TIMEOUT_CYCLES, timeout_o pulses once and the counter holds. State is unchanged.
  - The counter pauses in REPLAY.
- replay_cnt clears on entry to ISSUE.
- While in REPLAY, l1d_req_vld_o does not drop until l1d_req_rdy_i; the payload is stable while vld is held.

## Timing
- All outputs are combinational from state/registers except the handshake-qualified strobes: buf_alloc_vld_o, replay_req_rdy_o's response override, and resp_drop_o.
- Reset values:
  - state=IDLE, so ptw_req_rdy_o=1.
  - l1d_req_vld_o=0, buf_alloc_vld_o=0, replay_req_rdy_o=0, busy_o=0.
  - replay_cnt_o=0, timeout_o=0, err_id_mismatch_o=0, resp_drop_o=0.
- Accept to L1D vld: 1 cycle (IDLE capture at edge N, l1d_req_vld_o high in N+1). Minimum walk: request cycle 0, issue cycle 1, response in cycle 2 or later, back in IDLE in cycle 3.
- Replay: accepted at edge M, l1d_req_vld_o high in M+1.
- Reset asserted mid-walk: immediate return to IDLE, all registers cleared, and err_id_mismatch_o cleared too. There is no pending handshake after reset.

## Test plan
- New walk id=1, paddr=0x8000_1000, rdy_i=1 -> l1d_req_vld_o cycle 1, buf_alloc_vld_o=1 same cycle; response cycle 4 -> IDLE, busy_o=0 cycle 5.
- Walk issued, then 3 replays id=1, each taken by rdy_i -> three L1D requests with paddr 0x8000_1000, replay_cnt_o=3, no buf_alloc.
- l1d_req_rdy_i=0 for 5 cycles in ISSUE -> vld/payload held constant; flush_i cycle 3 -> IDLE cycle 4, no alloc. Also cover flush_i in the same cycle as l1d_req_rdy_i -> handshake wins, flush_pending set, resp_drop_o on the response.
- Flush in WAIT_RESP, then response -> resp_drop_o=1 on the response cycle, 0 afterwards.
- No response after issue with TIMEOUT_CYCLES=8 -> timeout_o single pulse 8 cycles after WAIT_RESP entry.
- Replay id=0 while held id=1 -> err_id_mismatch_o sticky 1; response and replay in the same cycle -> replay_req_rdy_o=0, IDLE next.

Source files
------------

// File: rtl/rvh_l1d_ptw_req_sched_if.sv
// rtl/rvh_l1d_ptw_req_sched_if.sv - PTW request scheduler handshake bundle
//
// Groups the four request/allocate channels of the PTW request scheduler:
//   ptw_req_*    new walk request from the MMU PTW (vld/id/paddr in, rdy out)
//   replay_req_* replay request from the PTW replay buffer (vld/id/paddr in, rdy out)
//   l1d_req_*    request to the L1D load-pipe PTW port (vld/id/paddr out, rdy in)
//   buf_alloc_*  replay-buffer allocate strobe (vld/id/paddr out)
// slave  : the scheduler side
// master : the surrounding PTW / replay buffer / L1D side
interface rvh_l1d_ptw_req_sched_if #(
    parameter int PTW_ID_WIDTH = 1,
    parameter int PADDR_WIDTH  = 56
);
    logic                    ptw_req_vld_i;
    logic [PTW_ID_WIDTH-1:0] ptw_req_id_i;
    logic [PADDR_WIDTH-1:0]  ptw_req_paddr_i;
    logic                    ptw_req_rdy_o;

    logic                    replay_req_vld_i;
    logic [PTW_ID_WIDTH-1:0] replay_req_id_i;
    logic [PADDR_WIDTH-1:0]  replay_req_paddr_i;
    logic                    replay_req_rdy_o;

    logic                    l1d_req_vld_o;
    logic [PTW_ID_WIDTH-1:0] l1d_req_id_o;
    logic [PADDR_WIDTH-1:0]  l1d_req_paddr_o;
    logic                    l1d_req_rdy_i;

    logic                    buf_alloc_vld_o;
    logic [PTW_ID_WIDTH-1:0] buf_alloc_id_o;
    logic [PADDR_WIDTH-1:0]  buf_alloc_paddr_o;

    modport slave (
        input  ptw_req_vld_i, ptw_req_id_i, ptw_req_paddr_i,
        output ptw_req_rdy_o,
        input  replay_req_vld_i, replay_req_id_i, replay_req_paddr_i,
        output replay_req_rdy_o,
        output l1d_req_vld_o, l1d_req_id_o, l1d_req_paddr_o,
        input  l1d_req_rdy_i,
        output buf_alloc_vld_o, buf_alloc_id_o, buf_alloc_paddr_o
    );

    modport master (
        output ptw_req_vld_i, ptw_req_id_i, ptw_req_paddr_i,
        input  ptw_req_rdy_o,
        output replay_req_vld_i, replay_req_id_i, replay_req_paddr_i,
        input  replay_req_rdy_o,
        input  l1d_req_vld_o, l1d_req_id_o, l1d_req_paddr_o,
        output l1d_req_rdy_i,
        input  buf_alloc_vld_o, buf_alloc_id_o, buf_alloc_paddr_o
    );
endinterface

// File: rtl/rvh_l1d_ptw_req_sched.sv
// rtl/rvh_l1d_ptw_req_sched.sv - single-outstanding PTW request scheduler into the L1D load pipe
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   bus (slave)              ptw_req / replay_req / l1d_req / buf_alloc channels
//   ptw_walk_resp_vld_i/rdy_i response handshake, observed only
//   flush_i                  sfence/flush of translation state
//   resp_drop_o              current response belongs to a flushed walk
//   busy_o                   a walk is outstanding
//   replay_cnt_o             replays of the current walk, saturating at 15
//   timeout_o                one-cycle pulse on response watchdog expiry
//   err_id_mismatch_o        sticky: a replay carried an ID other than the walk ID
module rvh_l1d_ptw_req_sched #(
    parameter int PTW_ID_WIDTH   = 1,
    parameter int PADDR_WIDTH    = 56,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_WIDTH       = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    rvh_l1d_ptw_req_sched_if.slave   bus,
    input  logic                     ptw_walk_resp_vld_i,
    input  logic                     ptw_walk_resp_rdy_i,
    input  logic                     flush_i,
    output logic                     resp_drop_o,
    output logic                     busy_o,
    output logic [3:0]               replay_cnt_o,
    output logic                     timeout_o,
    output logic                     err_id_mismatch_o
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_REPLAY    = 2'd3
    } state_e;

    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

    state_e                  state_q, state_d;
    logic [PTW_ID_WIDTH-1:0] hold_id_q, hold_id_d;
    logic [PADDR_WIDTH-1:0]  hold_paddr_q, hold_paddr_d;
    logic [PTW_ID_WIDTH-1:0] rep_id_q, rep_id_d;
    logic [PADDR_WIDTH-1:0]  rep_paddr_q, rep_paddr_d;
    logic [3:0]              replay_cnt_q, replay_cnt_d;
    logic [TO_WIDTH-1:0]     to_cnt_q, to_cnt_d;
    logic                    to_fired_q, to_fired_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    err_q, err_d;
    logic                    resp_hs;

    assign resp_hs = ptw_walk_resp_vld_i & ptw_walk_resp_rdy_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_id_q    <= '0;
            hold_paddr_q <= '0;
            rep_id_q     <= '0;
            rep_paddr_q  <= '0;
            replay_cnt_q <= '0;
            to_cnt_q     <= '0;
            to_fired_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_id_q    <= hold_id_d;
            hold_paddr_q <= hold_paddr_d;
            rep_id_q     <= rep_id_d;
            rep_paddr_q  <= rep_paddr_d;
            replay_cnt_q <= replay_cnt_d;
            to_cnt_q     <= to_cnt_d;
            to_fired_q   <= to_fired_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_id_d    = hold_id_q;
        hold_paddr_d = hold_paddr_q;
        rep_id_d     = rep_id_q;
        rep_paddr_d  = rep_paddr_q;
        replay_cnt_d = replay_cnt_q;
        to_cnt_d     = to_cnt_q;
        to_fired_d   = to_fired_q;
        flush_pend_d = flush_pend_q;
        err_d        = err_q;

        bus.ptw_req_rdy_o    = 1'b0;
        bus.replay_req_rdy_o = 1'b0;
        bus.l1d_req_vld_o    = 1'b0;
        bus.l1d_req_id_o     = hold_id_q;
        bus.l1d_req_paddr_o  = hold_paddr_q;
        bus.buf_alloc_vld_o  = 1'b0;
        timeout_o            = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.ptw_req_rdy_o = 1'b1;
                if (bus.ptw_req_vld_i) begin
                    hold_id_d    = bus.ptw_req_id_i;
                    hold_paddr_d = bus.ptw_req_paddr_i;
                    replay_cnt_d = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.l1d_req_vld_o = 1'b1;
                if (bus.l1d_req_rdy_i) begin
                    // Once L1D has taken the request the walk is in flight,
                    // so a coincident flush can only mark its response stale.
                    bus.buf_alloc_vld_o = 1'b1;
                    to_cnt_d            = '0;
                    to_fired_d          = 1'b0;
                    state_d             = S_WAIT_RESP;
                    if (flush_i) flush_pend_d = 1'b1;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RESP: begin
                // Counter saturates at the limit; the fired flag makes the
                // expiry a single pulse even though the count then holds.
                if (to_cnt_q != TO_LIMIT) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end else if (!to_fired_q) begin
                    timeout_o  = 1'b1;
                    to_fired_d = 1'b1;
                end
                if (resp_hs) begin
                    state_d = S_IDLE;
                end else begin
                    bus.replay_req_rdy_o = 1'b1;
                    if (flush_i) flush_pend_d = 1'b1;
                    if (bus.replay_req_vld_i) begin
                        rep_id_d    = bus.replay_req_id_i;
                        rep_paddr_d = bus.replay_req_paddr_i;
                        if (replay_cnt_q != 4'hf) replay_cnt_d = replay_cnt_q + 4'd1;
                        if (bus.replay_req_id_i != hold_id_q) err_d = 1'b1;
                        state_d = S_REPLAY;
                    end
                end
            end
            S_REPLAY: begin
                bus.l1d_req_vld_o   = 1'b1;
                bus.l1d_req_id_o    = rep_id_q;
                bus.l1d_req_paddr_o = rep_paddr_q;
                if (resp_hs) begin
                    state_d = S_IDLE;
                end else begin
                    if (flush_i) flush_pend_d = 1'b1;
                    if (bus.l1d_req_rdy_i) state_d = S_WAIT_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) flush_pend_d = 1'b0;
    end

    assign bus.buf_alloc_id_o    = hold_id_q;
    assign bus.buf_alloc_paddr_o = hold_paddr_q;
    assign resp_drop_o           = flush_pend_q & resp_hs;
    assign busy_o                = (state_q != S_IDLE);
    assign replay_cnt_o          = replay_cnt_q;
    assign err_id_mismatch_o     = err_q;
endmodule

// File: tb/tb_rvh_l1d_ptw_req_sched.sv
// tb/tb_rvh_l1d_ptw_req_sched.sv - self-checking bench for rvh_l1d_ptw_req_sched
module tb_rvh_l1d_ptw_req_sched;
    localparam int IDW = 1;
    localparam int PAW = 56;
    localparam int TO  = 8;
    localparam logic [55:0] PA1 = 56'h8000_1000;
    localparam logic [55:0] PA2 = 56'h0123_4560;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       resp_vld = 1'b0, resp_rdy = 1'b0, flush = 1'b0;
    logic       resp_drop, busy, timeout, err;
    logic [3:0] replay_cnt;

    int tests = 0, failed = 0, cyc = 0;
    int alloc_seen = 0, l1d_hs_seen = 0, to_seen = 0, to_cyc = -1, drop_seen = 0;

    rvh_l1d_ptw_req_sched_if #(.PTW_ID_WIDTH(IDW), .PADDR_WIDTH(PAW)) bus ();

    rvh_l1d_ptw_req_sched #(
        .PTW_ID_WIDTH(IDW), .PADDR_WIDTH(PAW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ptw_walk_resp_vld_i(resp_vld), .ptw_walk_resp_rdy_i(resp_rdy),
        .flush_i(flush), .resp_drop_o(resp_drop), .busy_o(busy),
        .replay_cnt_o(replay_cnt), .timeout_o(timeout), .err_id_mismatch_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The walk is described as "what is outstanding": nothing, a request
    // still waiting for L1D, an in-flight walk, or a replay waiting for L1D.
    localparam int M_NONE = 0, M_TO_L1D = 1, M_INFLIGHT = 2, M_REPLAY = 3;
    int          m_phase = M_NONE;
    int          m_replays = 0;       // unsaturated replay count
    int          m_wait = 0;          // unsaturated in-flight cycles since issue
    bit          m_err = 0, m_flushed = 0;
    logic [0:0]  m_wid = '0, m_rid = '0;
    logic [55:0] m_wpa = '0, m_rpa = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_phase <= M_NONE; m_replays <= 0; m_wait <= 0;
            m_err <= 0; m_flushed <= 0;
        end else begin
            case (m_phase)
                M_NONE: if (bus.ptw_req_vld_i) begin
                    m_wid <= bus.ptw_req_id_i; m_wpa <= bus.ptw_req_paddr_i;
                    m_replays <= 0; m_phase <= M_TO_L1D;
                end
                M_TO_L1D: if (bus.l1d_req_rdy_i) begin
                    m_phase <= M_INFLIGHT; m_wait <= 0;
                    if (flush) m_flushed <= 1;
                end else if (flush) m_phase <= M_NONE;
                M_INFLIGHT: begin
                    m_wait <= m_wait + 1;
                    if (resp_vld && resp_rdy) begin
                        m_phase <= M_NONE; m_flushed <= 0;
                    end else begin
                        if (flush) m_flushed <= 1;
                        if (bus.replay_req_vld_i) begin
                            m_rid <= bus.replay_req_id_i; m_rpa <= bus.replay_req_paddr_i;
                            m_replays <= m_replays + 1;
                            if (bus.replay_req_id_i != m_wid) m_err <= 1;
                            m_phase <= M_REPLAY;
                        end
                    end
                end
                default: begin
                    if (resp_vld && resp_rdy) begin
                        m_phase <= M_NONE; m_flushed <= 0;
                    end else begin
                        if (flush) m_flushed <= 1;
                        if (bus.l1d_req_rdy_i) m_phase <= M_INFLIGHT;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic hs;
        hs = resp_vld & resp_rdy;
        if (rst) begin
            chk("rst_ptw_rdy", bus.ptw_req_rdy_o, 1);
            chk("rst_l1d_vld", bus.l1d_req_vld_o, 0);
            chk("rst_alloc", bus.buf_alloc_vld_o, 0);
            chk("rst_replay_rdy", bus.replay_req_rdy_o, 0);
            chk("rst_busy", busy, 0);
            chk("rst_replay_cnt", replay_cnt, 0);
            chk("rst_timeout", timeout, 0);
            chk("rst_err", err, 0);
            chk("rst_drop", resp_drop, 0);
        end else begin
            chk("ptw_rdy", bus.ptw_req_rdy_o, m_phase == M_NONE);
            chk("l1d_vld", bus.l1d_req_vld_o, m_phase == M_TO_L1D || m_phase == M_REPLAY);
            if (m_phase == M_TO_L1D) begin
                chk("l1d_id", bus.l1d_req_id_o, m_wid);
                chk("l1d_paddr", bus.l1d_req_paddr_o, m_wpa);
            end else if (m_phase == M_REPLAY) begin
                chk("l1d_rep_id", bus.l1d_req_id_o, m_rid);
                chk("l1d_rep_paddr", bus.l1d_req_paddr_o, m_rpa);
            end
            chk("alloc_vld", bus.buf_alloc_vld_o, m_phase == M_TO_L1D && bus.l1d_req_rdy_i);
            if (bus.buf_alloc_vld_o) begin
                chk("alloc_id", bus.buf_alloc_id_o, m_wid);
                chk("alloc_paddr", bus.buf_alloc_paddr_o, m_wpa);
            end
            chk("replay_rdy", bus.replay_req_rdy_o, m_phase == M_INFLIGHT && !hs);
            chk("busy", busy, m_phase != M_NONE);
            chk("replay_cnt", replay_cnt, (m_replays > 15) ? 15 : m_replays);
            chk("timeout", timeout, m_phase == M_INFLIGHT && m_wait == TO);
            chk("err", err, m_err);
            chk("resp_drop", resp_drop, m_flushed && hs);
        end
        if (bus.buf_alloc_vld_o) alloc_seen++;
        if (bus.l1d_req_vld_o && bus.l1d_req_rdy_i) l1d_hs_seen++;
        if (timeout) begin to_seen++; to_cyc = cyc; end
        if (resp_drop) drop_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        bus.ptw_req_vld_i = 0; bus.replay_req_vld_i = 0;
        resp_vld = 0; resp_rdy = 0; flush = 0;
    endtask

    task automatic new_walk(input logic [0:0] id, input logic [55:0] pa);
        bus.ptw_req_vld_i = 1; bus.ptw_req_id_i = id; bus.ptw_req_paddr_i = pa;
        tick();
        bus.ptw_req_vld_i = 0;
    endtask

    task automatic respond();
        resp_vld = 1; resp_rdy = 1;
        tick();
        resp_vld = 0; resp_rdy = 0;
    endtask

    task automatic replay(input logic [0:0] id, input logic [55:0] pa);
        bus.replay_req_vld_i = 1; bus.replay_req_id_i = id; bus.replay_req_paddr_i = pa;
        tick();
        bus.replay_req_vld_i = 0;
        tick();   // REPLAY cycle, taken by l1d_req_rdy_i=1
    endtask

    initial begin
        int a0, h0, c0;
        logic [55:0] pa_snap;
        bus.ptw_req_vld_i = 0; bus.ptw_req_id_i = '0; bus.ptw_req_paddr_i = '0;
        bus.replay_req_vld_i = 0; bus.replay_req_id_i = '0; bus.replay_req_paddr_i = '0;
        bus.l1d_req_rdy_i = 1;
        tick(); tick();
        rst = 0;
        tick();

        // 1: basic walk
        a0 = alloc_seen;
        new_walk(1'b1, PA1);
        #1;
        chk("lit_issue_vld", bus.l1d_req_vld_o, 1);
        chk("lit_issue_paddr", bus.l1d_req_paddr_o, PA1);
        chk("lit_issue_alloc", bus.buf_alloc_vld_o, 1);
        tick(); tick();
        resp_vld = 1; resp_rdy = 1; #1;
        chk("lit_resp_replay_rdy", bus.replay_req_rdy_o, 0);
        tick(); clr(); #1;
        chk("lit_idle_busy", busy, 0);
        chk("lit_alloc_once", alloc_seen - a0, 1);

        // 2: three replays of the same walk
        a0 = alloc_seen; h0 = l1d_hs_seen;
        new_walk(1'b1, PA1); tick();
        for (int i = 0; i < 3; i++) replay(1'b1, PA1);
        chk("lit_replay_cnt3", replay_cnt, 4'd3);
        chk("lit_l1d_hs4", l1d_hs_seen - h0, 4);
        chk("lit_alloc_no_replay", alloc_seen - a0, 1);
        respond();

        // 3: L1D stalls, then flush drops the walk
        a0 = alloc_seen;
        bus.l1d_req_rdy_i = 0;
        new_walk(1'b1, PA2);
        pa_snap = bus.l1d_req_paddr_o;
        tick(); tick();
        chk("lit_hold_paddr", bus.l1d_req_paddr_o, pa_snap);
        chk("lit_hold_vld", bus.l1d_req_vld_o, 1);
        flush = 1; tick(); flush = 0; #1;
        chk("lit_flush_idle", busy, 0);
        chk("lit_flush_no_alloc", alloc_seen - a0, 0);

        // 3b: flush coincident with the L1D handshake
        new_walk(1'b0, PA2); tick();
        bus.l1d_req_rdy_i = 1; flush = 1; #1;
        chk("lit_flush_hs_alloc", bus.buf_alloc_vld_o, 1);
        tick(); flush = 0;
        resp_vld = 1; resp_rdy = 1; #1;
        chk("lit_flush_hs_drop", resp_drop, 1);
        tick(); clr();

        // 4: flush while in flight, then response
        d_start: begin
            new_walk(1'b1, PA1); tick();
            flush = 1; tick(); flush = 0; tick();
            resp_vld = 1; resp_rdy = 1; #1;
            chk("lit_drop_on_resp", resp_drop, 1);
            tick(); #1;
            chk("lit_drop_after", resp_drop, 0);
            clr();
        end

        // 5: watchdog
        to_seen = 0;
        new_walk(1'b1, PA1); tick();
        c0 = cyc;
        for (int i = 0; i < 14; i++) tick();
        chk("lit_to_pulses", to_seen, 1);
        chk("lit_to_offset", to_cyc - c0, TO);
        chk("lit_to_busy", busy, 1);
        respond();

        // 6: ID mismatch, replay saturation, response beats replay
        new_walk(1'b1, PA1); tick();
        replay(1'b0, PA2);
        chk("lit_err_set", err, 1);
        for (int i = 0; i < 16; i++) replay(1'b1, PA1);
        chk("lit_replay_sat", replay_cnt, 4'd15);
        bus.replay_req_vld_i = 1; resp_vld = 1; resp_rdy = 1; #1;
        chk("lit_resp_beats_replay", bus.replay_req_rdy_o, 0);
        tick(); clr(); #1;
        chk("lit_resp_idle", busy, 0);
        chk("lit_err_sticky", err, 1);

        // 7: asynchronous reset mid-walk
        bus.l1d_req_rdy_i = 0;
        new_walk(1'b1, PA1);
        rst = 1; #1;
        chk("lit_arst_busy", busy, 0);
        chk("lit_arst_err", err, 0);
        chk("lit_arst_vld", bus.l1d_req_vld_o, 0);
        tick(); rst = 0; bus.l1d_req_rdy_i = 1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench time limit");
    end
endmodule
